// File: rtl/register_file.sv
// ============================================================================
// Module      : register_file
// Description : Parameterised two-read / one-write register file. Each
//               register has a scoreboard busy bit, and a saturating counter
//               tracks committed writes. Register 0 is hardwired to zero.
//               Optional macro REGFILE_BYPASS_EN adds write-through
//               forwarding from the write port to both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [15:0]       write_count
);

  localparam logic [15:0]       C_COUNT_MAX = 16'hFFFF;
  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = '0;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [15:0]      count_q;
  logic [15:0]      count_d;

  logic w_commit;
  logic w_alloc;

  // A write commits only when it targets a real (non-zero) register.
  always_comb begin
    w_commit = reg_write && (wr_addr != C_ZERO_ADDR);
    w_alloc  = alloc_en && (alloc_addr != C_ZERO_ADDR);
  end

  // Next-state: write clears busy, alloc applied afterwards so it wins on a
  // same-address collision; register 0 is forced to zero / not busy.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    count_d = count_q;
    if (w_commit) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
      if (count_q != C_COUNT_MAX) begin
        count_d = count_q + 16'd1;
      end
    end
    if (w_alloc) begin
      busy_d[alloc_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear of data, busy bits and counter.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Read ports: stored state, optionally overridden by the in-flight write.
  always_comb begin
    rs1_data = (rs1_addr == C_ZERO_ADDR) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == C_ZERO_ADDR) ? '0 : regs_q[rs2_addr];
    rs1_busy = (rs1_addr == C_ZERO_ADDR) ? 1'b0 : busy_q[rs1_addr];
    rs2_busy = (rs2_addr == C_ZERO_ADDR) ? 1'b0 : busy_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    // Forwarded value is not busy unless the same register is being
    // re-allocated in this very cycle.
    if (w_commit && (rs1_addr == wr_addr)) begin
      rs1_data = wr_data;
      rs1_busy = w_alloc && (alloc_addr == wr_addr);
    end
    if (w_commit && (rs2_addr == wr_addr)) begin
      rs2_data = wr_data;
      rs2_busy = w_alloc && (alloc_addr == wr_addr);
    end
`endif
  end

  // Counter output straight from its flop.
  always_comb begin
    write_count = count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        CLK;
  logic        reset_n;
  logic        reg_write;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        alloc_en;
  logic [3:0]  alloc_addr;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [15:0] write_count;

  int errors = 0;
  int checks = 0;

  register_file #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .reg_write  (reg_write),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .write_count(write_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    reg_write  = 1'b0;
    wr_addr    = 4'd0;
    wr_data    = 16'h0;
    alloc_en   = 1'b0;
    alloc_addr = 4'd0;
    rs1_addr   = 4'd1;
    rs2_addr   = 4'd2;

    // Reset held for two cycles, then released
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_rs1_data", 32'(rs1_data), 32'h0);
    chk("rst_rs2_data", 32'(rs2_data), 32'h0);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'h0);
    chk("rst_rs2_busy", 32'(rs2_busy), 32'h0);
    chk("rst_count", 32'(write_count), 32'h0);

    // Write r5 = 8888, then hold with garbage on the write bus
    reg_write = 1'b1; wr_addr = 4'd5; wr_data = 16'h8888;
    tick();
    reg_write = 1'b0; wr_data = 16'hFFFF;
    rs1_addr = 4'd5;
    #1;
    chk("r5_written", 32'(rs1_data), 32'h8888);
    tick();
    chk("r5_hold", 32'(rs1_data), 32'h8888);
    chk("count_after_r5", 32'(write_count), 32'h1);

    // Write to r0 is discarded and not counted
    reg_write = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234;
    tick();
    reg_write = 1'b0;
    rs1_addr = 4'd0;
    #1;
    chk("r0_reads_zero", 32'(rs1_data), 32'h0);
    chk("count_r0_write", 32'(write_count), 32'h1);

    // Alloc r3, then commit a write that clears busy
    alloc_en = 1'b1; alloc_addr = 4'd3;
    tick();
    alloc_en = 1'b0;
    rs1_addr = 4'd3; rs2_addr = 4'd5;
    #1;
    chk("r3_busy_alloc", 32'(rs1_busy), 32'h1);
    chk("r5_not_busy", 32'(rs2_busy), 32'h0);
    reg_write = 1'b1; wr_addr = 4'd3; wr_data = 16'hABCD;
    tick();
    reg_write = 1'b0;
    #1;
    chk("r3_busy_cleared", 32'(rs1_busy), 32'h0);
    chk("r3_data", 32'(rs1_data), 32'hABCD);
    chk("count_r3", 32'(write_count), 32'h2);

    // Same-cycle alloc and write to r3: alloc wins, data still stored
    reg_write = 1'b1; wr_addr = 4'd3; wr_data = 16'h1111;
    alloc_en = 1'b1; alloc_addr = 4'd3;
    tick();
    reg_write = 1'b0; alloc_en = 1'b0;
    #1;
    chk("r3_busy_alloc_wins", 32'(rs1_busy), 32'h1);
    chk("r3_data_collide", 32'(rs1_data), 32'h1111);
    chk("count_collide", 32'(write_count), 32'h3);

    // Alloc to r0 ignored
    alloc_en = 1'b1; alloc_addr = 4'd0;
    tick();
    alloc_en = 1'b0;
    rs1_addr = 4'd0;
    #1;
    chk("r0_never_busy", 32'(rs1_busy), 32'h0);

    // Alloc r4 and write r6 in the same cycle
    alloc_en = 1'b1; alloc_addr = 4'd4;
    reg_write = 1'b1; wr_addr = 4'd6; wr_data = 16'h0606;
    tick();
    alloc_en = 1'b0; reg_write = 1'b0;
    rs1_addr = 4'd4; rs2_addr = 4'd6;
    #1;
    chk("r4_busy", 32'(rs1_busy), 32'h1);
    chk("r6_data", 32'(rs2_data), 32'h0606);
    chk("r6_not_busy", 32'(rs2_busy), 32'h0);
    chk("count_dual", 32'(write_count), 32'h4);

    // Bypass: make r7 busy, then write it while rs2 reads it
    alloc_en = 1'b1; alloc_addr = 4'd7;
    tick();
    alloc_en = 1'b0;
    reg_write = 1'b1; wr_addr = 4'd7; wr_data = 16'h5A5A;
    rs2_addr = 4'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", 32'(rs2_data), 32'h5A5A);
    chk("bypass_busy", 32'(rs2_busy), 32'h0);
`else
    chk("nobypass_data", 32'(rs2_data), 32'h0);
    chk("nobypass_busy", 32'(rs2_busy), 32'h1);
`endif
    tick();
    reg_write = 1'b0;
    #1;
    chk("r7_after_edge", 32'(rs2_data), 32'h5A5A);
    chk("r7_busy_after", 32'(rs2_busy), 32'h0);
    chk("count_r7", 32'(write_count), 32'h5);

    // Asynchronous reset between edges clears state immediately
    reg_write = 1'b1; wr_addr = 4'd9; wr_data = 16'h00FF;
    tick();
    reg_write = 1'b0;
    rs1_addr = 4'd9; rs2_addr = 4'd4;
    #1;
    chk("r9_written", 32'(rs1_data), 32'h00FF);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_r9", 32'(rs1_data), 32'h0);
    chk("async_r4_busy", 32'(rs2_busy), 32'h0);
    chk("async_count", 32'(write_count), 32'h0);

    // Writes and allocs ignored while reset is held
    reg_write = 1'b1; wr_addr = 4'd9; wr_data = 16'hBEEF;
    alloc_en = 1'b1; alloc_addr = 4'd4;
    tick();
    chk("rst_blocks_write", 32'(rs1_data), 32'h0);
    chk("rst_blocks_alloc", 32'(rs2_busy), 32'h0);
    chk("rst_blocks_count", 32'(write_count), 32'h0);

    // Release mid-cycle: first write takes effect at the next edge
    #2;
    reset_n = 1'b1;
    alloc_en = 1'b0;
    #1;
    chk("release_no_partial", 32'(rs1_data), 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("post_release_write", 32'(rs1_data), 32'hBEEF);
    chk("post_release_count", 32'(write_count), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
